// File: rtl/rvv_pkg.sv
// Shared RVV encoding constants and decode helpers used by the issue controller.
package rvv_pkg;

   localparam logic [6:0] OPV = 7'h57;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int VD_LSB     = 7;
   localparam int VD_MSB     = 11;
   localparam int F3_LSB     = 12;
   localparam int F3_MSB     = 14;
   localparam int VS1_LSB    = 15;
   localparam int VS1_MSB    = 19;
   localparam int VS2_LSB    = 20;
   localparam int VS2_MSB    = 24;

   typedef enum logic [2:0] {
      OPIVV = 3'b000,
      OPFVV = 3'b001,
      OPMVV = 3'b010,
      OPIVI = 3'b011,
      OPIVX = 3'b100,
      OPFVF = 3'b101,
      OPMVX = 3'b110,
      OPCFG = 3'b111
   } funct3_e;

   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] vd;
      funct3_e    funct3;
      logic [4:0] vs1;
      logic [4:0] vs2;
   } vinsn_t;

   function automatic vinsn_t decode(input logic [VS2_MSB:0] bits);
      vinsn_t d;
      d.opcode = bits[OPCODE_MSB:OPCODE_LSB];
      d.vd     = bits[VD_MSB:VD_LSB];
      d.funct3 = funct3_e'(bits[F3_MSB:F3_LSB]);
      d.vs1    = bits[VS1_MSB:VS1_LSB];
      d.vs2    = bits[VS2_MSB:VS2_LSB];
      return d;
   endfunction

   // Vector-vector forms read vs1; the scalar/immediate forms carry no vector in that field.
   function automatic logic reads_vs1(input funct3_e f);
      return (f == OPIVV) || (f == OPFVV) || (f == OPMVV);
   endfunction

endpackage

// File: rtl/rvv_insn_fifo.sv
// Small instruction buffer with a combinational head and registered occupancy flags.
module rvv_insn_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_insn,
   input  logic             in_vld,
   output logic             in_rdy,
   output logic [WIDTH-1:0] head,
   input  logic             pop,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [PTR_W:0]   count_next;
   logic             push;
   logic             do_pop;

   assign full   = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty  = (count_reg == '0);
   // Ready is held low for the whole reset interval, not just until the next edge.
   assign in_rdy = rst && !full;
   assign push   = in_vld && in_rdy;
   assign do_pop = pop && !empty;
   assign head   = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      if (push && !do_pop) begin
         count_next = count_reg + (PTR_W+1)'(1);
      end else if (do_pop && !push) begin
         count_next = count_reg - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_insn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/rvv_issue_ctrl.sv
// In-order vector issue stage: buffers fetched instructions and holds RAW-dependent ones
// until the producer's fixed-latency write has landed.
module rvv_issue_ctrl
   import rvv_pkg::*;
#(
   parameter int INSN_WIDTH = 32,
   parameter int NUM_VEC    = 32,
   parameter int PIPE_LAT   = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INSN_WIDTH-1:0] in_insn,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [INSN_WIDTH-1:0] insn_out,
   output logic                  insn_out_vld,
   output logic [NUM_VEC-1:0]    busy_vec,
   output logic [15:0]           stall_cnt,
   output logic                  idle
);

   localparam int CNT_W = $clog2(PIPE_LAT + 1);

   logic [INSN_WIDTH-1:0] head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   vinsn_t                dec;
   logic                  is_vec;
   logic                  src_busy;
   logic                  hazard;
   logic                  issue;

   logic [INSN_WIDTH-1:0] insn_out_reg;
   logic [INSN_WIDTH-1:0] insn_out_next;
   logic                  insn_out_vld_reg;
   logic [15:0]           stall_cnt_reg;
   logic [15:0]           stall_cnt_next;

   rvv_insn_fifo #(
      .WIDTH (INSN_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .in_insn (in_insn),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .head    (head),
      .pop     (pop),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign dec = decode(head[VS2_MSB:0]);

   always_comb begin
      is_vec         = 1'b0;
      src_busy       = 1'b0;
      hazard         = 1'b0;
      issue          = 1'b0;
      pop            = 1'b0;
      insn_out_next  = '0;
      stall_cnt_next = stall_cnt_reg;

      is_vec   = !fifo_empty && (dec.opcode == OPV) && (dec.funct3 != OPCFG);
      // Only RAW matters: a later write to a busy vd lands after the earlier one anyway.
      src_busy = busy_vec[dec.vs2] || (reads_vs1(dec.funct3) && busy_vec[dec.vs1]);
      hazard   = is_vec && src_busy;
      issue    = is_vec && !src_busy;
      pop      = !fifo_empty && !hazard;

      if (issue) begin
         insn_out_next = head;
      end
      if (hazard && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_next = stall_cnt_reg + 16'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg <= '0;
            end else if (issue && (dec.vd == 5'(gi))) begin
               cnt_reg <= CNT_W'(PIPE_LAT);
            end else if (cnt_reg != '0) begin
               cnt_reg <= cnt_reg - CNT_W'(1);
            end
         end

         assign busy_vec[gi] = (cnt_reg != '0);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         insn_out_reg     <= '0;
         insn_out_vld_reg <= 1'b0;
         stall_cnt_reg    <= '0;
      end else begin
         insn_out_reg     <= insn_out_next;
         insn_out_vld_reg <= issue;
         stall_cnt_reg    <= stall_cnt_next;
      end
   end

   assign insn_out     = insn_out_reg;
   assign insn_out_vld = insn_out_vld_reg;
   assign stall_cnt    = stall_cnt_reg;
   assign idle         = fifo_empty && (busy_vec == '0);

endmodule

// File: tb/tb_rvv_issue_ctrl.sv
// Scenario bench for rvv_issue_ctrl: a timing scoreboard predicts every issue edge,
// busy window and buffer occupancy; a second instance with a long latency covers saturation.
module tb_rvv_issue_ctrl;

   localparam int P       = 3;
   localparam int P_LONG  = 70000;
   localparam int DEPTH   = 4;

   localparam logic [31:0] I_VMV1   = 32'h5c0000d7; // v1 <- v0
   localparam logic [31:0] I_VMV2   = 32'h5c008157; // v2 <- v1
   localparam logic [31:0] I_VADD5  = 32'h000182d7; // v5 <- v0, v3
   localparam logic [31:0] I_NOP    = 32'h00000000;
   localparam logic [31:0] I_OPIVX6 = 32'h0000c357; // v6 <- v0, x1 (vs1 field = 1, not a vector)
   localparam logic [31:0] I_OPIVI4 = 32'h00103257; // v4 <- v1, imm
   localparam logic [31:0] I_CFG    = 32'h000070d7; // config, never issued

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_insn;
   logic        in_vld;
   logic        in_rdy;
   logic [31:0] insn_out;
   logic        insn_out_vld;
   logic [31:0] busy_vec;
   logic [15:0] stall_cnt;
   logic        idle;

   logic [31:0] in_insn_s;
   logic        in_vld_s;
   logic        in_rdy_s;
   logic [31:0] insn_out_s;
   logic        insn_out_vld_s;
   logic [31:0] busy_vec_s;
   logic [15:0] stall_cnt_s;
   logic        idle_s;

   always #5 clk = ~clk;

   rvv_issue_ctrl #(.INSN_WIDTH(32), .NUM_VEC(32), .PIPE_LAT(P), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_insn      (in_insn),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .insn_out     (insn_out),
      .insn_out_vld (insn_out_vld),
      .busy_vec     (busy_vec),
      .stall_cnt    (stall_cnt),
      .idle         (idle)
   );

   rvv_issue_ctrl #(.INSN_WIDTH(32), .NUM_VEC(32), .PIPE_LAT(P_LONG), .FIFO_DEPTH(DEPTH)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .in_insn      (in_insn_s),
      .in_vld       (in_vld_s),
      .in_rdy       (in_rdy_s),
      .insn_out     (insn_out_s),
      .insn_out_vld (insn_out_vld_s),
      .busy_vec     (busy_vec_s),
      .stall_cnt    (stall_cnt_s),
      .idle         (idle_s)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   typedef struct {logic [31:0] insn; int edge_no;} exp_t;
   typedef struct {int acc; int popped;} occ_t;
   typedef struct {int r; int t;} bev_t;

   exp_t sb_q[$];
   occ_t occ_q[$];
   bev_t bev_q[$];
   int   wr_t[32];
   int   last_pop;
   int   exp_stall;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int imax(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   function automatic int occ_at(input int c);
      int n = 0;
      foreach (occ_q[i]) if (occ_q[i].acc <= c && occ_q[i].popped > c) n++;
      return n;
   endfunction

   function automatic logic [31:0] busy_at(input int c);
      logic [31:0] b = '0;
      foreach (bev_q[i]) if (c >= bev_q[i].t && c <= bev_q[i].t + P - 1) b[bev_q[i].r] = 1'b1;
      return b;
   endfunction

   task automatic reset_model();
      sb_q.delete();
      occ_q.delete();
      bev_q.delete();
      for (int i = 0; i < 32; i++) wr_t[i] = -100;
      last_pop  = -100;
      exp_stall = 0;
   endtask

   // Entry accepted at edge a: earliest pop is one edge after it becomes head,
   // delayed until every vector source's producer is PIPE_LAT+1 edges old.
   task automatic model_accept(input logic [31:0] insn, input int a);
      logic [2:0] f3  = insn[14:12];
      int         hd  = imax(a, last_pop) + 1;
      int         e   = hd;
      if (insn[6:0] == 7'h57 && f3 != 3'b111) begin
         if (f3 <= 3'b010) e = imax(e, wr_t[insn[19:15]] + P + 1);
         e = imax(e, wr_t[insn[24:20]] + P + 1);
         exp_stall += e - hd;
         wr_t[insn[11:7]] = e;
         sb_q.push_back('{insn, e});
         bev_q.push_back('{int'(insn[11:7]), e});
      end
      last_pop = e;
      occ_q.push_back('{a, e});
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (insn_out_vld) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: insn_out=%h at cycle %0d, required no issue", insn_out, cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               checks += 2;
               if (insn_out !== e.insn) begin
                  errors++;
                  $display("FAIL issue_insn: got %h, required %h", insn_out, e.insn);
               end
               if (cyc !== e.edge_no) begin
                  errors++;
                  $display("FAIL issue_edge: %h issued at edge %0d, required edge %0d", e.insn, cyc, e.edge_no);
               end
               $display("issue %h at edge %0d", insn_out, cyc);
            end
         end else begin
            checks++;
            if (insn_out !== 32'h0) begin
               errors++;
               $display("FAIL nop_out: insn_out=%h with vld low, required 00000000", insn_out);
            end
         end
         checks++;
         if (busy_vec !== busy_at(cyc)) begin
            errors++;
            $display("FAIL busy_vec: got %h, required %h at edge %0d", busy_vec, busy_at(cyc), cyc);
         end
         checks++;
         if (idle !== (occ_at(cyc) == 0 && busy_at(cyc) == 0)) begin
            errors++;
            $display("FAIL idle: got %b at edge %0d", idle, cyc);
         end
      end
   end

   bit saw_full;

   task automatic push(input logic [31:0] insn);
      int  budget = 0;
      bit  done   = 1'b0;
      @(negedge clk);
      in_insn = insn;
      in_vld  = 1'b1;
      while (!done) begin
         checks++;
         if (in_rdy !== (occ_at(cyc) < DEPTH)) begin
            errors++;
            $display("FAIL in_rdy: got %b, required %b with %0d entries held", in_rdy, occ_at(cyc) < DEPTH, occ_at(cyc));
         end
         if (in_rdy) begin
            model_accept(insn, cyc + 1);
            $display("push %h at edge %0d", insn, cyc + 1);
            done = 1'b1;
            @(posedge clk);
         end else begin
            saw_full = 1'b1;
            budget++;
            if (budget > 50) begin
               checks++;
               errors++;
               $display("FAIL push_timeout: %h never accepted, in_rdy=%b", insn, in_rdy);
               done = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic release_in();
      @(negedge clk);
      in_vld  = 1'b0;
      in_insn = '0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (cyc <= last_pop + P + 1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d issues missing, required 0", name, sb_q.size());
      end
      checks++;
      if (stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL %s_stall_cnt: got %0d, required %0d", name, stall_cnt, exp_stall);
      end
      $display("%s done: stall_cnt=%0d", name, stall_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_vld = 1'b0; in_insn = '0; in_vld_s = 1'b0; in_insn_s = '0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (in_rdy !== 1'b0)        begin errors++; $display("FAIL rst_in_rdy: got %b, required 0", in_rdy); end
      if (insn_out !== 32'h0)     begin errors++; $display("FAIL rst_insn_out: got %h, required 0", insn_out); end
      if (insn_out_vld !== 1'b0)  begin errors++; $display("FAIL rst_vld: got %b, required 0", insn_out_vld); end
      if (stall_cnt !== 16'h0)    begin errors++; $display("FAIL rst_stall: got %h, required 0", stall_cnt); end
      if (busy_vec !== 32'h0)     begin errors++; $display("FAIL rst_busy: got %h, required 0", busy_vec); end
      rst = 1'b1;
      reset_model();
      @(negedge clk);
      checks += 3;
      if (in_rdy !== 1'b1)        begin errors++; $display("FAIL post_rst_in_rdy: got %b, required 1", in_rdy); end
      if (idle !== 1'b1)          begin errors++; $display("FAIL post_rst_idle: got %b, required 1", idle); end
      if (busy_vec !== 32'h0)     begin errors++; $display("FAIL post_rst_busy: got %h, required 0", busy_vec); end
      $display("reset released at edge %0d", cyc);
      #1 mon_en = 1'b1;
   endtask

   task automatic test_raw();
      int s0 = exp_stall;
      push(I_VMV1);
      push(I_VMV2);
      release_in();
      wait_drain("raw");
      checks++;
      if (exp_stall - s0 != 3 || stall_cnt !== 16'(exp_stall)) begin
         errors++;
         $display("FAIL raw_stall_delta: got stall_cnt %0d, required %0d", stall_cnt, s0 + 3);
      end
   endtask

   task automatic test_independent();
      push(I_VMV1);
      push(I_VADD5);
      release_in();
      wait_drain("independent");
   endtask

   task automatic test_nop_drop();
      push(I_VMV1);
      push(I_NOP);
      push(I_VADD5);
      release_in();
      wait_drain("nop_drop");
   endtask

   task automatic test_back_to_back();
      push(I_VMV1);
      push(I_OPIVX6);
      push(I_OPIVI4);
      push(I_CFG);
      push(I_VADD5);
      release_in();
      wait_drain("back_to_back");
   endtask

   task automatic test_backpressure();
      saw_full = 1'b0;
      push(I_VMV1);
      for (int i = 0; i < 5; i++) push(I_VMV2);
      release_in();
      wait_drain("backpressure");
      checks++;
      if (saw_full !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_full: in_rdy never low, required low with 4 entries held");
      end
   endtask

   task automatic test_reset_mid();
      push(I_VMV1);
      push(I_VMV2);
      push(I_VMV2);
      push(I_VMV2);
      mon_en = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_vec !== 32'h2) begin
         errors++;
         $display("FAIL mid_pre_busy: got %h, required 00000002", busy_vec);
      end
      in_vld = 1'b0;
      in_insn = '0;
      rst = 1'b0;
      #1;
      checks += 5;
      if (insn_out !== 32'h0)    begin errors++; $display("FAIL mid_insn_out: got %h, required 0", insn_out); end
      if (insn_out_vld !== 1'b0) begin errors++; $display("FAIL mid_vld: got %b, required 0", insn_out_vld); end
      if (busy_vec !== 32'h0)    begin errors++; $display("FAIL mid_busy: got %h, required 0", busy_vec); end
      if (stall_cnt !== 16'h0)   begin errors++; $display("FAIL mid_stall: got %h, required 0", stall_cnt); end
      if (in_rdy !== 1'b0)       begin errors++; $display("FAIL mid_in_rdy: got %b, required 0", in_rdy); end
      @(negedge clk);
      rst = 1'b1;
      reset_model();
      #1;
      checks += 3;
      if (idle !== 1'b1)         begin errors++; $display("FAIL mid_post_idle: got %b, required 1", idle); end
      if (in_rdy !== 1'b1)       begin errors++; $display("FAIL mid_post_in_rdy: got %b, required 1", in_rdy); end
      if (busy_vec !== 32'h0)    begin errors++; $display("FAIL mid_post_busy: got %h, required 0", busy_vec); end
      mon_en = 1'b1;
      repeat (8) @(negedge clk);
      wait_drain("reset_mid");
   endtask

   task automatic test_saturation();
      @(negedge clk);
      checks++;
      if (in_rdy_s !== 1'b1) begin errors++; $display("FAIL sat_in_rdy: got %b, required 1", in_rdy_s); end
      in_insn_s = I_VMV1;
      in_vld_s  = 1'b1;
      @(negedge clk);
      in_insn_s = I_VMV2;
      @(negedge clk);
      in_vld_s  = 1'b0;
      in_insn_s = '0;
      checks++;
      if (insn_out_vld_s !== 1'b1 || insn_out_s !== I_VMV1) begin
         errors++;
         $display("FAIL sat_producer: got vld=%b insn=%h, required 1 %h", insn_out_vld_s, insn_out_s, I_VMV1);
      end
      repeat (1000) @(negedge clk);
      checks++;
      if (stall_cnt_s !== 16'd1000) begin errors++; $display("FAIL sat_partial: got %0d, required 1000", stall_cnt_s); end
      $display("saturation partial: stall_cnt=%0d", stall_cnt_s);
      repeat (68000) @(negedge clk);
      checks += 3;
      if (stall_cnt_s !== 16'hFFFF) begin errors++; $display("FAIL sat_value: got %h, required ffff", stall_cnt_s); end
      if (insn_out_vld_s !== 1'b0)  begin errors++; $display("FAIL sat_held: vld=%b, required 0", insn_out_vld_s); end
      if (busy_vec_s !== 32'h2)     begin errors++; $display("FAIL sat_busy: got %h, required 00000002", busy_vec_s); end
      $display("saturation final: stall_cnt=%h", stall_cnt_s);
   endtask

   initial begin
      test_reset();
      test_raw();
      test_independent();
      test_nop_drop();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
